// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared state type and default parameters for the control sequencer
package cpu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_STEPS   = 8;
  localparam int DEF_IR_WIDTH    = 16;
  localparam int DEF_OPC_WIDTH   = 6;
  localparam int DEF_DECODE_STEP = 2;

endpackage

// File: rtl/opcode_onehot_decoder.sv
// rtl/opcode_onehot_decoder.sv - combinational opcode to one-hot decode, all-zero when disabled
module opcode_onehot_decoder #(
  parameter int OPC_WIDTH = 6
) (
  input  logic                      i_en,
  input  logic [OPC_WIDTH-1:0]      i_opc,
  output logic [2**OPC_WIDTH-1:0]   o_d
);

  always_comb begin
    o_d = '0;
    if (i_en) begin
      o_d[i_opc] = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - one-hot timing step sequencer with opcode latch, decode and halt
module control_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int                    NUM_STEPS   = DEF_NUM_STEPS,
  parameter int                    IR_WIDTH    = DEF_IR_WIDTH,
  parameter int                    OPC_WIDTH   = DEF_OPC_WIDTH,
  parameter int                    DECODE_STEP = DEF_DECODE_STEP,
  parameter logic [OPC_WIDTH-1:0]  HALT_OPCODE = '1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_enable,
  input  logic                            i_stall,
  input  logic                            i_end_instr,
  input  logic [IR_WIDTH-1:0]             i_ir,
  output logic [NUM_STEPS-1:0]            o_t,
  output logic [$clog2(NUM_STEPS)-1:0]    o_step_num,
  output logic [OPC_WIDTH-1:0]            o_opcode,
  output logic [IR_WIDTH-OPC_WIDTH-1:0]   o_operand,
  output logic [2**OPC_WIDTH-1:0]         o_d,
  output logic                            o_instr_done,
  output logic                            o_overrun,
  output logic                            o_halted
);

  localparam int                   SW    = $clog2(NUM_STEPS);
  localparam logic [SW-1:0]        C_DEC = SW'(DECODE_STEP);
  localparam logic [NUM_STEPS-1:0] C_T0  = {{(NUM_STEPS-1){1'b0}}, 1'b1};

  seq_state_e                     r_state, w_state_nxt;
  logic [NUM_STEPS-1:0]           r_t, w_t_nxt;
  logic                           r_done, w_done_nxt;
  logic                           r_overrun, w_overrun_nxt;
  logic [OPC_WIDTH-1:0]           r_opcode;
  logic [IR_WIDTH-OPC_WIDTH-1:0]  r_operand;
  logic                           w_latch;
  logic [SW-1:0]                  w_step;
  logic [OPC_WIDTH-1:0]           w_ir_opc;
  logic                           w_dec_en;
  logic [OPC_WIDTH-1:0]           w_dec_sel;

  assign w_ir_opc = i_ir[IR_WIDTH-1 -: OPC_WIDTH];

  // Binary index is derived from the one-hot register so the two can never disagree.
  always_comb begin
    w_step = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (r_t[i]) begin
        w_step = w_step | SW'(i);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_t       <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_opcode  <= '0;
      r_operand <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_t       <= w_t_nxt;
      r_done    <= w_done_nxt;
      r_overrun <= w_overrun_nxt;
      if (w_latch) begin
        r_opcode  <= w_ir_opc;
        r_operand <= i_ir[IR_WIDTH-OPC_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_t_nxt       = r_t;
    w_done_nxt    = r_done;
    w_overrun_nxt = r_overrun;
    w_latch       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_t_nxt    = '0;
        w_done_nxt = 1'b0;
        if (i_enable) begin
          w_state_nxt = ST_RUN;
          w_t_nxt     = C_T0;
        end
      end
      ST_RUN: begin
        if (i_enable && !i_stall) begin
          w_done_nxt = 1'b0;
          w_latch    = (w_step == C_DEC);
          if (i_end_instr && (w_step >= C_DEC)) begin
            w_t_nxt    = C_T0;
            w_done_nxt = 1'b1;
          end else if ((w_step == C_DEC) && (w_ir_opc == HALT_OPCODE)) begin
            w_state_nxt = ST_HALT;
            w_t_nxt     = '0;
          end else if (r_t[NUM_STEPS-1]) begin
            w_t_nxt       = C_T0;
            w_done_nxt    = 1'b1;
            w_overrun_nxt = 1'b1;
          end else begin
            w_t_nxt = r_t << 1;
          end
        end
      end
      ST_HALT: begin
        w_t_nxt    = '0;
        w_done_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_t_nxt     = '0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // Live IR is decoded during the decode step; later steps use the latched opcode.
  assign w_dec_en  = (r_state == ST_RUN) && (w_step >= C_DEC);
  assign w_dec_sel = (w_step == C_DEC) ? w_ir_opc : r_opcode;

  opcode_onehot_decoder #(
    .OPC_WIDTH (OPC_WIDTH)
  ) u_dec (
    .i_en  (w_dec_en),
    .i_opc (w_dec_sel),
    .o_d   (o_d)
  );

  assign o_t          = r_t;
  assign o_step_num   = w_step;
  assign o_opcode     = r_opcode;
  assign o_operand    = r_operand;
  assign o_instr_done = r_done;
  assign o_overrun    = r_overrun;
  assign o_halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer with a step-level reference model
module tb_control_sequencer;

  localparam int N   = 8;
  localparam int DEC = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, stall = 1'b0, end_instr = 1'b0;
  logic [15:0] ir = '0;
  logic [7:0]  t;
  logic [2:0]  step_num;
  logic [5:0]  opcode;
  logic [9:0]  operand;
  logic [63:0] d;
  logic        instr_done, overrun, halted;

  control_sequencer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_stall      (stall),
    .i_end_instr  (end_instr),
    .i_ir         (ir),
    .o_t          (t),
    .o_step_num   (step_num),
    .o_opcode     (opcode),
    .o_operand    (operand),
    .o_d          (d),
    .o_instr_done (instr_done),
    .o_overrun    (overrun),
    .o_halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  t;
    logic [2:0]  sn;
    logic [5:0]  opc;
    logic [9:0]  opr;
    logic [63:0] d;
    logic        done;
    logic        ovr;
    logic        halt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int       m_state;
  int       m_step;
  bit [5:0] m_opc;
  bit [9:0] m_opr;
  bit       m_done, m_ovr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void m_reset();
    m_state = M_IDLE; m_step = -1; m_opc = '0; m_opr = '0; m_done = 0; m_ovr = 0;
  endfunction

  // One clock edge of the sequencer at the level of "which step are we in".
  function automatic void m_edge(bit rst, bit en, bit st, bit ei, logic [15:0] irv);
    if (!rst) begin
      m_reset();
    end else if (m_state == M_IDLE) begin
      if (en) begin m_state = M_RUN; m_step = 0; m_done = 0; end
    end else if (m_state == M_RUN && en && !st) begin
      m_done = 0;
      if (m_step == DEC) begin m_opc = irv[15:10]; m_opr = irv[9:0]; end
      if (ei && m_step >= DEC) begin
        m_step = 0; m_done = 1;
      end else if (m_step == DEC && irv[15:10] == 6'h3F) begin
        m_state = M_HALT; m_step = -1;
      end else if (m_step == N - 1) begin
        m_step = 0; m_done = 1; m_ovr = 1;
      end else begin
        m_step = m_step + 1;
      end
    end
  endfunction

  function automatic exp_t m_outputs(logic [15:0] irv);
    exp_t e;
    e.t    = (m_step < 0) ? 8'h00 : 8'(1 << m_step);
    e.sn   = (m_step < 0) ? 3'd0 : 3'(m_step);
    e.opc  = m_opc;
    e.opr  = m_opr;
    e.d    = '0;
    if (m_state == M_RUN && m_step == DEC) e.d = 64'd1 << irv[15:10];
    if (m_state == M_RUN && m_step > DEC)  e.d = 64'd1 << m_opc;
    e.done = m_done;
    e.ovr  = m_ovr;
    e.halt = (m_state == M_HALT);
    return e;
  endfunction

  task automatic cycle(input bit rst, input bit en, input bit st, input bit ei, input logic [15:0] irv);
    @(negedge clk);
    rst_n = rst; enable = en; stall = st; end_instr = ei; ir = irv;
    m_edge(rst, en, st, ei, irv);
    q.push_back(m_outputs(irv));
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_t", 64'(t), 64'h0);
    chk("async_rst_overrun", 64'(overrun), 64'h0);
    chk("async_rst_done", 64'(instr_done), 64'h0);
    m_reset();
  endtask

  // Monitor: every post-edge output is compared with the oldest pending expectation.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("t", 64'(t), 64'(e.t));
        chk("step_num", 64'(step_num), 64'(e.sn));
        chk("opcode", 64'(opcode), 64'(e.opc));
        chk("operand", 64'(operand), 64'(e.opr));
        chk("d", d, e.d);
        chk("instr_done", 64'(instr_done), 64'(e.done));
        chk("overrun", 64'(overrun), 64'(e.ovr));
        chk("halted", 64'(halted), 64'(e.halt));
      end
    end
  end

  initial begin
    m_reset();
    // reset held with enable high, then first enable edge gives T[0]
    repeat (3) cycle(0, 1, 0, 0, 16'h0000);
    cycle(1, 1, 0, 0, 16'h0000);
    // opcode 3 / operand 5, end at T[4]
    repeat (4) cycle(1, 1, 0, 0, 16'h0C05);
    cycle(1, 1, 0, 1, 16'h0C05);
    // stall at T[3] for three cycles
    repeat (3) cycle(1, 1, 0, 0, 16'h0C05);
    repeat (3) cycle(1, 1, 1, 0, 16'h0C05);
    cycle(1, 1, 0, 0, 16'h0C05);
    cycle(1, 1, 0, 1, 16'h0C05);
    // enable low holds
    repeat (2) cycle(1, 0, 0, 0, 16'h0400);
    // opcode 1 without end: wrap and sticky overrun
    repeat (9) cycle(1, 1, 0, 0, 16'h0400);
    repeat (3) cycle(1, 1, 0, 0, 16'h1402);
    cycle(1, 1, 0, 1, 16'h1402);
    // end during fetch ignored, then halt opcode
    cycle(1, 1, 0, 0, 16'hFC00);
    cycle(1, 1, 0, 1, 16'hFC00);
    cycle(1, 1, 0, 0, 16'hFC00);
    repeat (4) cycle(1, 1, 0, 1, 16'h0C05);
    cycle(0, 1, 0, 0, 16'h0000);
    cycle(1, 1, 0, 0, 16'h0000);
    // mid-instruction asynchronous reset at T[5]
    repeat (5) cycle(1, 1, 0, 0, 16'h0800);
    async_reset();
    cycle(0, 0, 0, 0, 16'h0800);
    cycle(1, 1, 0, 0, 16'h0800);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      rst = (m_state == M_HALT) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 99) != 0);
      cycle(rst, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0, 16'($urandom));
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 8: number of one-hot timing steps, legal range 4..32.
REQ-002 SHALL have parameter IR_WIDTH, default 16: instruction width.
REQ-003 SHALL have parameter OPC_WIDTH, default 6: opcode field width, taken from IR MSBs.
REQ-004 SHALL have parameter DECODE_STEP, default 2: decode step index, legal range 1..NUM_STEPS-2.
REQ-005 SHALL have parameter HALT_OPCODE, default all-ones: opcode that halts the sequencer.
REQ-006 SHALL use one clock and an asynchronous, active-low reset:
  Clock  in  1  rising-edge clock
  Reset  in  1  asynchronous active-low reset
REQ-007 SHALL provide these data ports:
  Enable  in  1  leave IDLE / permit stepping
  Stall  in  1  hold current step (memory wait)
  EndInstr  in  1  terminate current instruction
  IRIn  in  IR_WIDTH  instruction register contents
  T  out  NUM_STEPS  one-hot timing step
  StepNum  out  clog2(NUM_STEPS)  binary index of active step
  Opcode  out  OPC_WIDTH  latched opcode
  Operand  out  IR_WIDTH-OPC_WIDTH  latched low IR field
  D  out  2**OPC_WIDTH  one-hot opcode decode
  InstrDone  out  1  one-cycle instruction-complete pulse
  Overrun  out  1  sticky: step count exhausted without EndInstr
  Halted  out  1  HALT state indicator

Function
REQ-008 SHALL implement states IDLE, RUN and HALT.
REQ-009 IDLE: T=0, StepNum=0; SHALL go to RUN with T[0]=1 on the first edge with Enable=1.
REQ-010 RUN: on each edge with Enable=1 and Stall=0, SHALL advance T[k] to T[k+1]; with Enable=0 or Stall=1, T SHALL hold.
REQ-011 Priority per edge: Reset > Stall/Enable hold > EndInstr > normal advance.
REQ-012 EndInstr SHALL be honoured only when StepNum >= DECODE_STEP; then the next step SHALL be T[0].
REQ-013 EndInstr at StepNum < DECODE_STEP (fetch) SHALL be ignored.
REQ-014 At step NUM_STEPS-1 with no EndInstr, advance SHALL wrap to T[0] and set Overrun (sticky until reset).
REQ-015 While StepNum == DECODE_STEP, D SHALL be the combinational decode of IRIn[IR_WIDTH-1 -: OPC_WIDTH].
REQ-016 At the edge leaving DECODE_STEP, SHALL latch Opcode and Operand from IRIn.
REQ-017 At StepNum > DECODE_STEP, D SHALL decode the latched Opcode.
REQ-018 At StepNum < DECODE_STEP, D SHALL be 0.
REQ-019 D SHALL always be one-hot or zero.
REQ-020 If the latched Opcode == HALT_OPCODE, the edge leaving DECODE_STEP SHALL enter HALT instead of DECODE_STEP+1.
REQ-021 HALT: T=0, Halted=1, Opcode and Operand held; only Reset SHALL exit.
REQ-022 InstrDone SHALL be registered and high for exactly the first cycle of T[0] following an EndInstr or wrap.
REQ-023 InstrDone SHALL NOT assert on the IDLE-to-RUN entry.
REQ-024 InstrDone SHALL stay high while Stall holds that T[0] cycle.
REQ-025 StepNum SHALL always equal the index of the set bit of T; it SHALL be 0 when T=0.

Reset
REQ-026 Reset low SHALL asynchronously force: state IDLE, T=0, StepNum=0, Opcode=0, Operand=0, InstrDone=0, Overrun=0, Halted=0.
REQ-027 Reset asserted mid-instruction SHALL discard the instruction and produce no InstrDone.
REQ-028 After Reset rises, the first Enable=1 edge SHALL produce T[0].

Structure
REQ-029 Package cpu_seq_pkg SHALL hold the state enum (IDLE/RUN/HALT) and the default parameter constants.
REQ-030 Sub-module opcode_onehot_decoder (OPC_WIDTH to 2**OPC_WIDTH, combinational) SHALL produce D.
REQ-031 The step register SHALL be held one-hot; StepNum SHALL be derived from it or kept as a parallel counter checked by assertion.

Verification
REQ-032 Reset low, Enable=1 for 3 cycles, Reset high, Enable=1 -> T=0 throughout reset; T=8'h01 one edge later; InstrDone=0.
REQ-033 IRIn=16'h0C05, EndInstr at T[4] -> D[3]=1 from T[2]; Opcode=6'h03 and Operand=10'h005 latched; T[0] next with InstrDone=1 for 1 cycle.
REQ-034 Stall high 3 cycles at T[3] -> T stays 8'h08 for 4 cycles total, then 8'h10; latched Opcode unchanged.
REQ-035 No EndInstr, opcode 6'h01 -> T passes T[7], wraps to 8'h01; Overrun=1 and stays 1 through later instructions; InstrDone pulses.
REQ-036 EndInstr at T[1]; separately IRIn[15:10]=6'h3F -> T[1] ignored, advance to T[2]; halt opcode gives T=0 and Halted=1 after the T[2] edge, held until Reset.
REQ-037 Reset low at T[5] mid-instruction -> immediate T=0, Overrun=0, no InstrDone pulse.
